// File: rtl/pipelined_cla_addsub_if.sv
// Handshake and data bundle for pipelined_cla_addsub.
// Ports (signals):
//   in_valid/in_ready   - operand-side handshake
//   a, b, cin, sub      - operands, carry-in, add/subtract select
//   out_valid/out_ready - result-side handshake
//   sum, cout, ovf, zero - result and flags
// Modports: master drives operands and out_ready; slave is the adder's view.
interface pipelined_cla_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit lookahead group per
// pipeline stage, one operation per cycle at any WIDTH (multiple of 4).
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pipelined_cla_addsub_if.slave (operand/result handshakes, flags)
// Optional feature: define CLA_PIPE_FLAGS_EN to build the signed-overflow and
// zero flags; without it ovf and zero are tied low and no sign-bit pipeline or
// zero detect is built.
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_cla_addsub_if.slave bus
);
    localparam int unsigned GW = 4;
    localparam int unsigned NG = WIDTH / GW;

    // 4-bit group: returns {carry_out, sum[3:0]} with flattened lookahead carries.
    function automatic logic [GW:0] cla4(
        input logic [GW-1:0] x,
        input logic [GW-1:0] y,
        input logic          ci
    );
        logic [GW-1:0] g;
        logic [GW-1:0] p;
        logic [GW:0]   c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[GW], p ^ c[GW-1:0]};
    endfunction

    logic             advance;
    logic [WIDTH-1:0] bx;
    logic             out_v_q;
    logic             cout_q;
    logic [WIDTH-1:0] sum_q;
`ifdef CLA_PIPE_FLAGS_EN
    logic             ovf_q;
    logic             zero_q;
`endif

    // Global stall: everything moves together or nothing moves.
    assign advance      = !out_v_q || bus.out_ready;
    assign bus.in_ready = advance;
    assign bx           = bus.sub ? ~bus.b : bus.b;

    assign bus.out_valid = out_v_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef CLA_PIPE_FLAGS_EN
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
`else
    assign bus.ovf       = 1'b0;
    assign bus.zero      = 1'b0;
`endif

    // Stage k resolves group k; earlier stages feed it their registered carry,
    // the finished low sum bits and the still-unused operand slices.
    for (genvar k = 0; k < NG; k++) begin : stg
        logic                v_in;
        logic [GW-1:0]       ga;
        logic [GW-1:0]       gb;
        logic                ci;
        logic [GW:0]         res;
        logic [GW*(k+1)-1:0] sum_d;
`ifdef CLA_PIPE_FLAGS_EN
        logic                sa_in;
        logic                sb_in;
`endif

        if (k == 0) begin : src
            assign v_in = bus.in_valid;
            assign ga   = bus.a[GW-1:0];
            assign gb   = bx[GW-1:0];
            assign ci   = bus.cin;
`ifdef CLA_PIPE_FLAGS_EN
            assign sa_in = bus.a[WIDTH-1];
            assign sb_in = bx[WIDTH-1];
`endif
        end else begin : src
            assign v_in = stg[k-1].op.v_q;
            assign ga   = stg[k-1].op.a_q[GW-1:0];
            assign gb   = stg[k-1].op.bx_q[GW-1:0];
            assign ci   = stg[k-1].op.c_q;
`ifdef CLA_PIPE_FLAGS_EN
            assign sa_in = stg[k-1].op.sa_q;
            assign sb_in = stg[k-1].op.sb_q;
`endif
        end

        assign res = cla4(ga, gb, ci);

        if (k == 0) begin : lo
            assign sum_d = res[GW-1:0];
        end else begin : lo
            assign sum_d = {res[GW-1:0], stg[k-1].op.part_q};
        end

        if (k < NG - 1) begin : op
            // Operand bits still waiting for their group.
            localparam int unsigned RW = WIDTH - GW * (k + 1);

            logic                v_q;
            logic                c_q;
            logic [RW-1:0]       a_q;
            logic [RW-1:0]       bx_q;
            logic [GW*(k+1)-1:0] part_q;
            logic [RW-1:0]       a_d;
            logic [RW-1:0]       bx_d;
`ifdef CLA_PIPE_FLAGS_EN
            logic                sa_q;
            logic                sb_q;
`endif

            if (k == 0) begin : rem
                assign a_d  = bus.a[WIDTH-1:GW];
                assign bx_d = bx[WIDTH-1:GW];
            end else begin : rem
                assign a_d  = stg[k-1].op.a_q[RW+GW-1:GW];
                assign bx_d = stg[k-1].op.bx_q[RW+GW-1:GW];
            end

            // Intermediate stage register; data only loads behind a valid op.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q    <= 1'b0;
                    c_q    <= 1'b0;
                    a_q    <= '0;
                    bx_q   <= '0;
                    part_q <= '0;
`ifdef CLA_PIPE_FLAGS_EN
                    sa_q   <= 1'b0;
                    sb_q   <= 1'b0;
`endif
                end else if (advance) begin
                    v_q <= v_in;
                    if (v_in) begin
                        c_q    <= res[GW];
                        a_q    <= a_d;
                        bx_q   <= bx_d;
                        part_q <= sum_d;
`ifdef CLA_PIPE_FLAGS_EN
                        sa_q   <= sa_in;
                        sb_q   <= sb_in;
`endif
                    end
                end
            end
        end else begin : fin
            // Last stage register doubles as the output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_v_q <= 1'b0;
                    sum_q   <= '0;
                    cout_q  <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
                    ovf_q   <= 1'b0;
                    zero_q  <= 1'b0;
`endif
                end else if (advance) begin
                    out_v_q <= v_in;
                    if (v_in) begin
                        sum_q  <= sum_d;
                        cout_q <= res[GW];
`ifdef CLA_PIPE_FLAGS_EN
                        ovf_q  <= (sa_in == sb_in) && (sum_d[WIDTH-1] != sa_in);
                        zero_q <= ~|sum_d;
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
`timescale 1ns/1ps
module tb_pipelined_cla_addsub;
    localparam int N_RAND = 2000;
`ifdef CLA_PIPE_FLAGS_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipelined_cla_addsub_if #(.WIDTH(8))  i8  ();
    pipelined_cla_addsub_if #(.WIDTH(16)) i16 ();
    pipelined_cla_addsub_if #(.WIDTH(32)) i32 ();

    pipelined_cla_addsub #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    pipelined_cla_addsub #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
    pipelined_cla_addsub #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    res_t q8[$];
    res_t q16[$];
    res_t q32[$];
    res_t obs8, obs16, obs32;
    logic dlv8, dlv16, dlv32, acc8, acc16, acc32, ov8, rdy8, st16, st32;
    int   cyc_obs;

    // Independent arithmetic reference.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [31:0] mask;
        logic [31:0] bx;
        logic [32:0] full;
        logic        am, bm;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bx     = (sub ? ~b : b) & mask;
        full   = {1'b0, a & mask} + {1'b0, bx} + 33'(cin);
        r.sum  = full[31:0] & mask;
        r.cout = full[w];
        am     = a[w-1];
        bm     = bx[w-1];
        r.ovf  = FLAGS & (am == bm) & (r.sum[w-1] != am);
        r.zero = FLAGS & (r.sum == 32'd0);
        r.cyc  = 0;
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Sample all DUTs mid-cycle, log accepts into the scoreboards, step one edge.
    task automatic tick();
        res_t r;
        @(negedge clk);
        cyc_obs = cyc;
        ov8   = i8.out_valid;
        rdy8  = i8.in_ready;
        dlv8  = i8.out_valid && i8.out_ready;
        dlv16 = i16.out_valid && i16.out_ready;
        dlv32 = i32.out_valid && i32.out_ready;
        st16  = i16.out_valid && !i16.out_ready;
        st32  = i32.out_valid && !i32.out_ready;
        acc8  = i8.in_valid && i8.in_ready;
        acc16 = i16.in_valid && i16.in_ready;
        acc32 = i32.in_valid && i32.in_ready;
        obs8  = '{32'(i8.sum), i8.cout, i8.ovf, i8.zero, cyc};
        obs16 = '{32'(i16.sum), i16.cout, i16.ovf, i16.zero, cyc};
        obs32 = '{i32.sum, i32.cout, i32.ovf, i32.zero, cyc};
        if (acc8) begin
            r = model(8, 32'(i8.a), 32'(i8.b), i8.cin, i8.sub);
            r.cyc = cyc;
            q8.push_back(r);
        end
        if (acc16) begin
            r = model(16, 32'(i16.a), 32'(i16.b), i16.cin, i16.sub);
            r.cyc = cyc;
            q16.push_back(r);
        end
        if (acc32) begin
            r = model(32, i32.a, i32.b, i32.cin, i32.sub);
            r.cyc = cyc;
            q32.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        i8.in_valid  = 1'b0; i8.a  = '0; i8.b  = '0; i8.cin  = 1'b0; i8.sub  = 1'b0; i8.out_ready  = 1'b1;
        i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.cin = 1'b0; i16.sub = 1'b0; i16.out_ready = 1'b1;
        i32.in_valid = 1'b0; i32.a = '0; i32.b = '0; i32.cin = 1'b0; i32.sub = 1'b0; i32.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_held: out_valid=%b in_ready=%b, want 0/1", i8.out_valid, i8.in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (i8.sum !== 8'h00 || i8.cout !== 1'b0 || i8.ovf !== 1'b0 || i8.zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b zero=%b, want all 0",
                     i8.sum, i8.cout, i8.ovf, i8.zero);
        end
        n_checks++;
        if (i8.out_valid !== 1'b0 || i16.out_valid !== 1'b0 || i32.out_valid !== 1'b0 || i8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_valid: out_valid=%b/%b/%b in_ready=%b, want 0/0/0 and 1",
                     i8.out_valid, i16.out_valid, i32.out_valid, i8.in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h05};
        logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h07};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        logic       vs [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] es [3] = '{8'h00, 8'h80, 8'hFE};
        logic       ec [3] = '{1'b1, 1'b0, 1'b0};
        logic       ev [3] = '{1'b0, 1'b1, 1'b0};
        logic       ez [3] = '{1'b1, 1'b0, 1'b0};
        logic       got;
        int         acc_cyc;
        for (int i = 0; i < 3; i++) begin
            i8.out_ready = 1'b1;
            i8.in_valid  = 1'b1;
            i8.a = va[i]; i8.b = vb[i]; i8.cin = vc[i]; i8.sub = vs[i];
            tick();
            acc_cyc = cyc_obs;
            i8.in_valid = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                tick();
                if (dlv8) begin
                    got = 1'b1;
                    n_checks++;
                    if (obs8.sum[7:0] !== es[i] || obs8.cout !== ec[i] ||
                        obs8.ovf !== (ev[i] & FLAGS) || obs8.zero !== (ez[i] & FLAGS)) begin
                        n_fail++;
                        $display("FAIL vector%0d: sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b", i,
                                 obs8.sum[7:0], obs8.cout, obs8.ovf, obs8.zero,
                                 es[i], ec[i], ev[i] & FLAGS, ez[i] & FLAGS);
                    end
                    n_checks++;
                    if (cyc_obs - acc_cyc != 2) begin
                        n_fail++;
                        $display("FAIL vector%0d_latency: got %0d cycles, want 2", i, cyc_obs - acc_cyc);
                    end
                end
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL vector%0d_timeout: no result within 8 cycles, want one", i);
            end
            q8.delete();
        end
    endtask

    task automatic test_backpressure();
        int   k = 0;
        int   d = 0;
        int   stalls = 0;
        res_t e;
        q8.delete();
        for (int n = 0; n < 20; n++) begin
            i8.out_ready = (n >= 6);
            i8.in_valid  = (k < 3);
            i8.a = 8'(k + 1); i8.b = 8'(k + 1); i8.cin = 1'b0; i8.sub = 1'b0;
            tick();
            if (acc8) k++;
            if (ov8 && !dlv8) begin
                stalls++;
                n_checks++;
                if (obs8.sum[7:0] !== 8'h02 || rdy8 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold: sum=%h in_ready=%b, want 02/0", obs8.sum[7:0], rdy8);
                end
            end
            if (dlv8) begin
                n_checks++;
                if (q8.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: sum=%h delivered, want nothing", obs8.sum[7:0]);
                end else begin
                    e = q8.pop_front();
                    if (obs8.sum !== e.sum || obs8.cout !== e.cout || obs8.sum[7:0] !== 8'(2 * (d + 1))) begin
                        n_fail++;
                        $display("FAIL bp_order%0d: sum=%h cout=%b, want sum=%h cout=%b",
                                 d, obs8.sum[7:0], obs8.cout, 8'(2 * (d + 1)), e.cout);
                    end
                    d++;
                end
            end
        end
        n_checks++;
        if (d != 3 || stalls != 4) begin
            n_fail++;
            $display("FAIL bp_count: delivered=%0d stall_cycles=%0d, want 3 and 4", d, stalls);
        end
        i8.in_valid  = 1'b0;
        i8.out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int   k = 0;
        int   d = 0;
        res_t e;
        q8.delete();
        for (int n = 0; n < 60 && d < 24; n++) begin
            i8.out_ready = 1'b1;
            i8.in_valid  = (k < 24);
            i8.a   = 8'($urandom);
            i8.b   = 8'($urandom);
            i8.cin = 1'($urandom);
            i8.sub = 1'($urandom);
            tick();
            if (acc8) k++;
            if (dlv8) begin
                n_checks++;
                if (q8.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: sum=%h delivered, want nothing", obs8.sum[7:0]);
                end else begin
                    e = q8.pop_front();
                    if (obs8.sum !== e.sum || obs8.cout !== e.cout || obs8.ovf !== e.ovf || obs8.zero !== e.zero) begin
                        n_fail++;
                        $display("FAIL b2b_result%0d: sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b", d,
                                 obs8.sum[7:0], obs8.cout, obs8.ovf, obs8.zero, e.sum[7:0], e.cout, e.ovf, e.zero);
                    end
                    n_checks++;
                    if (cyc_obs - e.cyc != 2) begin
                        n_fail++;
                        $display("FAIL b2b_latency%0d: got %0d, want 2", d, cyc_obs - e.cyc);
                    end
                    d++;
                end
            end
        end
        n_checks++;
        if (d != 24) begin
            n_fail++;
            $display("FAIL b2b_count: delivered=%0d, want 24", d);
        end
        i8.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   seen = 0;
        logic got = 1'b0;
        q8.delete();
        i8.out_ready = 1'b1;
        i8.in_valid  = 1'b1;
        i8.a = 8'h10; i8.b = 8'h20; i8.cin = 1'b0; i8.sub = 1'b0;
        tick();
        i8.a = 8'h30; i8.b = 8'h01;
        tick();
        i8.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_immediate: out_valid=%b in_ready=%b, want 0/1", i8.out_valid, i8.in_ready);
        end
        q8.delete(); q16.delete(); q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ov8) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_stale: out_valid seen %0d cycles after reset, want 0", seen);
        end
        i8.in_valid = 1'b1;
        i8.a = 8'h33; i8.b = 8'h11;
        tick();
        i8.in_valid = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            tick();
            if (dlv8) begin
                got = 1'b1;
                n_checks++;
                if (obs8.sum[7:0] !== 8'h44 || obs8.cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_mid_after: sum=%h cout=%b, want 44/0", obs8.sum[7:0], obs8.cout);
                end
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL rst_mid_timeout: no result after reset, want sum=44");
        end
        q8.delete();
    endtask

    task automatic test_random();
        int   sent16 = 0, sent32 = 0, got16 = 0, got32 = 0;
        int   last16 = -1, last32 = -1;
        int   lat;
        res_t e;
        q16.delete(); q32.delete();
        for (int n = 0; n < 40000; n++) begin
            if (sent16 >= N_RAND && sent32 >= N_RAND && q16.size() == 0 && q32.size() == 0) break;
            i16.in_valid  = (sent16 < N_RAND) && ($urandom_range(0, 3) != 0);
            i16.a         = 16'(rnd_op());
            i16.b         = 16'(rnd_op());
            i16.cin       = 1'($urandom);
            i16.sub       = 1'($urandom);
            i16.out_ready = (n < 200) || ($urandom_range(0, 2) != 0);
            i32.in_valid  = (sent32 < N_RAND) && ($urandom_range(0, 3) != 0);
            i32.a         = rnd_op();
            i32.b         = rnd_op();
            i32.cin       = 1'($urandom);
            i32.sub       = 1'($urandom);
            i32.out_ready = (n < 200) || ($urandom_range(0, 2) != 0);
            tick();
            if (acc16) sent16++;
            if (acc32) sent32++;
            if (dlv16) begin
                got16++;
                n_checks++;
                if (q16.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd16_extra: sum=%h delivered, want nothing", obs16.sum[15:0]);
                end else begin
                    e = q16.pop_front();
                    if (obs16.sum !== e.sum || obs16.cout !== e.cout || obs16.ovf !== e.ovf || obs16.zero !== e.zero) begin
                        n_fail++;
                        $display("FAIL rnd16_result: sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                                 obs16.sum[15:0], obs16.cout, obs16.ovf, obs16.zero, e.sum[15:0], e.cout, e.ovf, e.zero);
                    end
                    lat = cyc_obs - e.cyc;
                    n_checks++;
                    if ((e.cyc > last16) ? (lat != 4) : (lat < 4)) begin
                        n_fail++;
                        $display("FAIL rnd16_latency: got %0d, want 4 (more only after a stall)", lat);
                    end
                end
            end
            if (dlv32) begin
                got32++;
                n_checks++;
                if (q32.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd32_extra: sum=%h delivered, want nothing", obs32.sum);
                end else begin
                    e = q32.pop_front();
                    if (obs32.sum !== e.sum || obs32.cout !== e.cout || obs32.ovf !== e.ovf || obs32.zero !== e.zero) begin
                        n_fail++;
                        $display("FAIL rnd32_result: sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                                 obs32.sum, obs32.cout, obs32.ovf, obs32.zero, e.sum, e.cout, e.ovf, e.zero);
                    end
                    lat = cyc_obs - e.cyc;
                    n_checks++;
                    if ((e.cyc > last32) ? (lat != 8) : (lat < 8)) begin
                        n_fail++;
                        $display("FAIL rnd32_latency: got %0d, want 8 (more only after a stall)", lat);
                    end
                end
            end
            if (st16) last16 = cyc_obs;
            if (st32) last32 = cyc_obs;
        end
        n_checks++;
        if (got16 != N_RAND || got32 != N_RAND || q16.size() != 0 || q32.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_complete: delivered %0d/%0d, pending %0d/%0d, want %0d each and none pending",
                     got16, got32, q16.size(), q32.size(), N_RAND);
        end
        i16.in_valid = 1'b0;
        i32.in_valid = 1'b0;
    endtask

    initial begin
        idle_all();
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
